acc_dispatcher: RTL and testbench
=================================

ACC_DISPATCHER -- requirements
Module: acc_dispatcher

Interface
REQ-001 The block SHALL have these parameters:
- ACC_DATA_WIDTH, default 64, operand/result width.
- ACC_INSTR_WIDTH, default 32, instruction width.
- ACC_REG_ADDR_WIDTH, default 5, destination register index width.
- CMD_DEPTH, default 4, command FIFO entries; SHALL be a power of 2, minimum 2.
- MAX_OUTSTANDING, default 4, maximum commands in the block: queued plus sent-but-unanswered.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i  in  1  the block's only clock.
- rst_i  in  1  reset; asynchronous, active-high.
- issue_valid_i  in  1  core offers a command.
- issue_ready_o  out  1  block accepts the command.
- issue_inst_i  in  ACC_INSTR_WIDTH  instruction; rd = bits [11:7].
- issue_rs1_i, issue_rs2_i  in  ACC_DATA_WIDTH  operand values.
- flush_i  in  1  drop queued, unsent commands.
- cmd_valid_o  out  1  command to accelerator valid.
- cmd_ready_i  in  1  accelerator accepts the command.
- cmd_inst_o  out  ACC_INSTR_WIDTH  command instruction.
- cmd_rs1_o, cmd_rs2_o  out  ACC_DATA_WIDTH  command operands.
- resp_valid_i  in  1  accelerator response valid.
- resp_ready_o  out  1  block accepts the response.
- resp_data_i  in  ACC_DATA_WIDTH  response data.
- resp_rd_i  in  ACC_REG_ADDR_WIDTH  response destination register.
- wb_valid_o  out  1  writeback valid.
- wb_ready_i  in  1  core writeback accepts.
- wb_data_o  out  ACC_DATA_WIDTH  writeback data.
- wb_rd_o  out  ACC_REG_ADDR_WIDTH  writeback register.
- rd_pending_o  out  2^ACC_REG_ADDR_WIDTH  scoreboard; one bit per register with a result pending.
- busy_o  out  1  any command queued, in flight or awaiting writeback.
- resp_err_o  out  1  one-cycle pulse on an unexpected response.

Function
REQ-003 A command SHALL be accepted on issue_valid_i && issue_ready_o.
REQ-004 issue_ready_o SHALL be 1 only when all of these hold: FIFO not full; queued+outstanding < MAX_OUTSTANDING; flush_i = 0; rd = 0 or rd_pending_o[rd] = 0. This path is combinational from issue_inst_i.
REQ-005 An accepted command SHALL be written to the FIFO, with no bypass; cmd_valid_o SHALL rise at the earliest on the cycle after acceptance.
REQ-006 cmd_valid_o SHALL equal "FIFO not empty". cmd_* outputs SHALL present the FIFO head and SHALL hold stable while cmd_valid_o && !cmd_ready_i.
REQ-007 On a cmd handshake the head SHALL be popped and the outstanding counter incremented, saturating at MAX_OUTSTANDING.
REQ-008 Accepting with rd != 0 SHALL set rd_pending_o[rd] on the next cycle. rd = 0 SHALL never set a bit.
REQ-009 resp_ready_o SHALL equal !wb_valid_o || wb_ready_i, forming a one-entry writeback register.
REQ-010 On a resp handshake the block SHALL register data and rd into the wb register, set wb_valid_o next cycle (latency 1), and decrement the outstanding counter.
REQ-011 On a wb handshake the block SHALL clear rd_pending_o[wb_rd_o] next cycle and drop wb_valid_o unless a new response loads in the same cycle.
REQ-012 A resp handshake while outstanding = 0 SHALL assert resp_err_o for one cycle and leave the counter at 0; the data is still written back.
REQ-013 On flush_i = 1 all FIFO entries SHALL be discarded and their rd_pending bits cleared. A cmd handshake in the same cycle SHALL complete and count as outstanding; its pending bit is kept.
REQ-014 Same cycle, wb clears rd X while an issue targets X: the issue SHALL stall, since the pending bit is still 1 that cycle, and SHALL be accepted next cycle.
REQ-015 Simultaneous push and pop SHALL keep the FIFO occupancy unchanged. Pointers SHALL wrap modulo CMD_DEPTH.
REQ-016 busy_o SHALL be (FIFO not empty) || outstanding != 0 || wb_valid_o.

Reset
REQ-017 While rst_i = 1 the block SHALL be empty: FIFO pointers, outstanding counter, rd_pending_o, wb_valid_o, cmd_valid_o, busy_o and resp_err_o SHALL be 0; data outputs SHALL be 0.
REQ-018 Reset mid-operation SHALL discard all queued, in-flight and writeback state immediately, asynchronously. issue_ready_o SHALL be 1 on the first cycle after release if issue_valid_i is presented.

Structure
REQ-019 Package acc_pkg SHALL hold the default widths, instr_t, data_t, reg_addr_t, and a cmd_t struct {inst, rs1, rs2}.
REQ-020 The FIFO SHALL be the sub-module acc_cmd_fifo, parameterised by depth and cmd_t, with full, empty and count outputs.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Issue inst rd=3 at cycle 0, cmd_ready_i=1 -> cmd_valid_o=1 at cycle 1, rd_pending_o[3]=1 from cycle 1. Then resp rd=3, data=0xDEAD -> wb_valid_o next cycle with wb_data_o=0xDEAD; bit 3 clears after wb handshake.
- cmd_ready_i=0, issue 5 commands with distinct rd -> 4 accepted; issue_ready_o=0 on the 5th; cmd_inst_o stable.
- Issue rd=7 twice back-to-back -> second stalls until wb of rd=7 completes, then is accepted the cycle after.
- 3 queued, flush_i with a cmd handshake in the same cycle -> outstanding=1, FIFO empty, only the handshaken rd remains pending.
- resp_valid_i with outstanding=0 -> resp_err_o one-cycle pulse, counter stays 0. Separately, rst_i mid-burst -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/acc_pkg.sv
// acc_pkg: default widths and shared command types for the accelerator dispatcher
package acc_pkg;
  localparam int DEF_DATA_W     = 64;
  localparam int DEF_INSTR_W    = 32;
  localparam int DEF_REG_ADDR_W = 5;
  typedef logic [DEF_INSTR_W-1:0]    instr_t;
  typedef logic [DEF_DATA_W-1:0]     data_t;
  typedef logic [DEF_REG_ADDR_W-1:0] reg_addr_t;
  typedef struct packed {
    instr_t inst;
    data_t  rs1;
    data_t  rs2;
  } cmd_t;
endpackage

// File: rtl/acc_cmd_fifo.sv
// acc_cmd_fifo: power-of-2 command queue with flush, full/empty and occupancy count
module acc_cmd_fifo import acc_pkg::*; #(
  parameter int  DEPTH = 4,
  parameter type T     = cmd_t
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  T                         data_i,
  output T                         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  assign full_o  = cnt_q == DEPTH[AW:0];
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  // storage is not reset; empty_o masks stale contents
  always_ff @(posedge clk_i)
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  // pointers wrap naturally at DEPTH; flush drops everything queued
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push_i);
      rd_q  <= rd_q + AW'(pop_i);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
endmodule

// File: rtl/acc_dispatcher.sv
// acc_dispatcher: queues core commands to an accelerator, tracks pending rds and writes responses back
module acc_dispatcher import acc_pkg::*; #(
  parameter int ACC_DATA_WIDTH     = DEF_DATA_W,
  parameter int ACC_INSTR_WIDTH    = DEF_INSTR_W,
  parameter int ACC_REG_ADDR_WIDTH = DEF_REG_ADDR_W,
  parameter int CMD_DEPTH          = 4,
  parameter int MAX_OUTSTANDING    = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               issue_valid_i,
  output logic                               issue_ready_o,
  input  logic [ACC_INSTR_WIDTH-1:0]         issue_inst_i,
  input  logic [ACC_DATA_WIDTH-1:0]          issue_rs1_i,
  input  logic [ACC_DATA_WIDTH-1:0]          issue_rs2_i,
  input  logic                               flush_i,
  output logic                               cmd_valid_o,
  input  logic                               cmd_ready_i,
  output logic [ACC_INSTR_WIDTH-1:0]         cmd_inst_o,
  output logic [ACC_DATA_WIDTH-1:0]          cmd_rs1_o,
  output logic [ACC_DATA_WIDTH-1:0]          cmd_rs2_o,
  input  logic                               resp_valid_i,
  output logic                               resp_ready_o,
  input  logic [ACC_DATA_WIDTH-1:0]          resp_data_i,
  input  logic [ACC_REG_ADDR_WIDTH-1:0]      resp_rd_i,
  output logic                               wb_valid_o,
  input  logic                               wb_ready_i,
  output logic [ACC_DATA_WIDTH-1:0]          wb_data_o,
  output logic [ACC_REG_ADDR_WIDTH-1:0]      wb_rd_o,
  output logic [2**ACC_REG_ADDR_WIDTH-1:0]   rd_pending_o,
  output logic                               busy_o,
  output logic                               resp_err_o
);
  typedef struct packed {
    logic [ACC_INSTR_WIDTH-1:0] inst;
    logic [ACC_DATA_WIDTH-1:0]  rs1;
    logic [ACC_DATA_WIDTH-1:0]  rs2;
  } cmd_lt;
  localparam int NR = 2**ACC_REG_ADDR_WIDTH;
  localparam int CW = $clog2(CMD_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = (CW > OW ? CW : OW) + 1;
  cmd_lt                         head;
  logic                          full, empty, push, pop, rsp, wbh;
  logic [CW-1:0]                 cnt;
  logic [OW-1:0]                 out_q, out_d;
  logic [NR-1:0]                 pend_q, pend_d, qmask_q, qmask_d;
  logic                          wb_valid_q, err_q;
  logic [ACC_DATA_WIDTH-1:0]     wb_data_q;
  logic [ACC_REG_ADDR_WIDTH-1:0] wb_rd_q, issue_rd, head_rd;
  assign issue_rd      = issue_inst_i[7 +: ACC_REG_ADDR_WIDTH];
  assign head_rd       = head.inst[7 +: ACC_REG_ADDR_WIDTH];
  assign issue_ready_o = !rst_i && !full && !flush_i
                         && (SW'(cnt) + SW'(out_q) < SW'(MAX_OUTSTANDING))
                         && (issue_rd == '0 || !pend_q[issue_rd]);
  assign push          = issue_valid_i && issue_ready_o;
  assign cmd_valid_o   = !empty;
  assign pop           = !empty && cmd_ready_i;
  assign cmd_inst_o    = empty ? '0 : head.inst;
  assign cmd_rs1_o     = empty ? '0 : head.rs1;
  assign cmd_rs2_o     = empty ? '0 : head.rs2;
  assign resp_ready_o  = !rst_i && (!wb_valid_q || wb_ready_i);
  assign rsp           = resp_valid_i && resp_ready_o;
  assign wbh           = wb_valid_q && wb_ready_i;
  assign wb_valid_o    = wb_valid_q;
  assign wb_data_o     = wb_data_q;
  assign wb_rd_o       = wb_rd_q;
  assign rd_pending_o  = pend_q;
  assign busy_o        = !empty || out_q != '0 || wb_valid_q;
  assign resp_err_o    = err_q;
  assign out_d         = out_q + OW'(pop && out_q != OW'(MAX_OUTSTANDING)) - OW'(rsp && out_q != '0);
  acc_cmd_fifo #(.DEPTH(CMD_DEPTH), .T(cmd_lt)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush_i),
    .data_i  ({issue_inst_i, issue_rs1_i, issue_rs2_i}),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (cnt)
  );
  // qmask tracks rds still sitting in the queue so a flush can release exactly those
  always_comb begin
    pend_d  = pend_q;
    qmask_d = qmask_q;
    if (pop) qmask_d[head_rd] = 1'b0;
    if (wbh) pend_d[wb_rd_q] = 1'b0;
    if (flush_i) begin
      pend_d  = pend_d & ~qmask_d;
      qmask_d = '0;
    end
    if (push && issue_rd != '0) begin
      pend_d[issue_rd]  = 1'b1;
      qmask_d[issue_rd] = 1'b1;
    end
  end
  // state update; a fresh response takes priority over draining the writeback slot
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      out_q      <= '0;
      pend_q     <= '0;
      qmask_q    <= '0;
      err_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
    end else begin
      out_q   <= out_d;
      pend_q  <= pend_d;
      qmask_q <= qmask_d;
      err_q   <= rsp && out_q == '0;
      if (rsp) begin
        wb_valid_q <= 1'b1;
        wb_data_q  <= resp_data_i;
        wb_rd_q    <= resp_rd_i;
      end else if (wbh) wb_valid_q <= 1'b0;
    end
endmodule

// File: tb/tb_acc_dispatcher.sv
// tb_acc_dispatcher: directed checks of issue, dispatch, scoreboard, flush, error and reset behaviour
module tb_acc_dispatcher;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0, flush = 1'b0, cmd_ready = 1'b0;
  logic        resp_valid = 1'b0, wb_ready = 1'b0;
  logic [31:0] issue_inst = '0;
  logic [63:0] issue_rs1 = '0, issue_rs2 = '0, resp_data = '0;
  logic [4:0]  resp_rd = '0;
  logic        issue_ready, cmd_valid, resp_ready, wb_valid, busy, resp_err;
  logic [31:0] cmd_inst, rd_pending;
  logic [63:0] cmd_rs1, cmd_rs2, wb_data;
  logic [4:0]  wb_rd;
  logic [31:0] inst_b, inst_h;
  int          checks = 0, failures = 0;
  acc_dispatcher dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .issue_valid_i (issue_valid),
    .issue_ready_o (issue_ready),
    .issue_inst_i  (issue_inst),
    .issue_rs1_i   (issue_rs1),
    .issue_rs2_i   (issue_rs2),
    .flush_i       (flush),
    .cmd_valid_o   (cmd_valid),
    .cmd_ready_i   (cmd_ready),
    .cmd_inst_o    (cmd_inst),
    .cmd_rs1_o     (cmd_rs1),
    .cmd_rs2_o     (cmd_rs2),
    .resp_valid_i  (resp_valid),
    .resp_ready_o  (resp_ready),
    .resp_data_i   (resp_data),
    .resp_rd_i     (resp_rd),
    .wb_valid_o    (wb_valid),
    .wb_ready_i    (wb_ready),
    .wb_data_o     (wb_data),
    .wb_rd_o       (wb_rd),
    .rd_pending_o  (rd_pending),
    .busy_o        (busy),
    .resp_err_o    (resp_err)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mk(int rd);
    return (32'(rd) << 7) | 32'h0000_000B;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    issue_rs1 = 64'h1;
    issue_rs2 = 64'h2;
    #3;
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pending", rd_pending, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_err", resp_err, 0);
    check("rst_cmd_inst", cmd_inst, 0);
    check("rst_wb_data", wb_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    issue_valid = 1'b1;
    issue_inst = mk(3);
    cmd_ready = 1'b1;
    #1 check("s1_ready", issue_ready, 1);
    cyc();
    issue_valid = 1'b0;
    #1 check("s1_cmd_valid", cmd_valid, 1);
    check("s1_cmd_inst", cmd_inst, mk(3));
    check("s1_cmd_rs1", cmd_rs1, 64'h1);
    check("s1_pending", rd_pending, 32'h8);
    cyc();
    check("s1_popped", cmd_valid, 0);
    check("s1_busy_flight", busy, 1);
    resp_valid = 1'b1;
    resp_rd = 5'd3;
    resp_data = 64'hDEAD;
    #1 check("s1_resp_ready", resp_ready, 1);
    cyc();
    resp_valid = 1'b0;
    check("s1_wb_valid", wb_valid, 1);
    check("s1_wb_data", wb_data, 64'hDEAD);
    check("s1_wb_rd", wb_rd, 3);
    check("s1_pending_wb", rd_pending, 32'h8);
    wb_ready = 1'b1;
    cyc();
    wb_ready = 1'b0;
    check("s1_wb_done", wb_valid, 0);
    check("s1_pending_clr", rd_pending, 0);
    check("s1_idle", busy, 0);
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue_valid = 1'b1;
      issue_inst = mk(i + 1);
      #1 check($sformatf("s2_ready%0d", i), issue_ready, i < 4);
      cyc();
    end
    issue_valid = 1'b0;
    #1 check("s2_pending", rd_pending, 32'h1E);
    check("s2_head", cmd_inst, mk(1));
    cyc();
    cyc();
    check("s2_head_stable", cmd_inst, mk(1));
    check("s2_valid_stable", cmd_valid, 1);
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("s2_order%0d", i), cmd_inst, mk(i + 1));
      cyc();
    end
    cmd_ready = 1'b0;
    check("s2_drained", cmd_valid, 0);
    issue_valid = 1'b1;
    issue_inst = mk(9);
    #1 check("s2_max_out", issue_ready, 0);
    issue_valid = 1'b0;
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      resp_valid = 1'b1;
      resp_rd = 5'(i + 1);
      resp_data = 64'(i + 1);
      cyc();
    end
    resp_valid = 1'b0;
    check("s2_last_wb", wb_data, 64'h4);
    check("s2_no_err", resp_err, 0);
    cyc();
    check("s2_pending_clr", rd_pending, 0);
    check("s2_idle", busy, 0);
    wb_ready = 1'b0;
    cmd_ready = 1'b1;
    issue_valid = 1'b1;
    issue_inst = mk(7);
    #1 check("s3_first", issue_ready, 1);
    cyc();
    inst_b = mk(7) | 32'h0100_0000;
    issue_inst = inst_b;
    #1 check("s3_stall0", issue_ready, 0);
    cyc();
    check("s3_stall1", issue_ready, 0);
    resp_valid = 1'b1;
    resp_rd = 5'd7;
    resp_data = 64'h77;
    cyc();
    resp_valid = 1'b0;
    wb_ready = 1'b1;
    #1 check("s3_stall_wb", issue_ready, 0);
    cyc();
    wb_ready = 1'b0;
    #1 check("s3_accept", issue_ready, 1);
    check("s3_bit_clr", rd_pending[7], 0);
    cyc();
    issue_valid = 1'b0;
    #1 check("s3_pending", rd_pending, 32'h80);
    check("s3_cmd", cmd_inst, inst_b);
    cyc();
    resp_valid = 1'b1;
    cyc();
    resp_valid = 1'b0;
    wb_ready = 1'b1;
    cyc();
    wb_ready = 1'b0;
    check("s3_idle", busy, 0);
    cmd_ready = 1'b0;
    for (int i = 10; i < 13; i++) begin
      issue_valid = 1'b1;
      issue_inst = mk(i);
      cyc();
    end
    issue_valid = 1'b0;
    cmd_ready = 1'b1;
    flush = 1'b1;
    #1 check("s4_flush_block", issue_ready, 0);
    check("s4_pend_before", rd_pending, 32'h1C00);
    cyc();
    flush = 1'b0;
    cmd_ready = 1'b0;
    #1 check("s4_empty", cmd_valid, 0);
    check("s4_pending", rd_pending, 32'h400);
    check("s4_busy", busy, 1);
    resp_valid = 1'b1;
    resp_rd = 5'd10;
    resp_data = 64'hA;
    wb_ready = 1'b1;
    cyc();
    resp_valid = 1'b0;
    check("s4_resp_ok", resp_err, 0);
    check("s4_wb", wb_valid, 1);
    cyc();
    check("s4_pend_clr", rd_pending, 0);
    check("s4_idle", busy, 0);
    resp_valid = 1'b1;
    resp_rd = 5'd2;
    resp_data = 64'hBEEF;
    cyc();
    resp_valid = 1'b0;
    check("s5_err", resp_err, 1);
    check("s5_wb_data", wb_data, 64'hBEEF);
    check("s5_busy_wb", busy, 1);
    cyc();
    check("s5_err_pulse", resp_err, 0);
    check("s5_cnt_zero", busy, 0);
    wb_ready = 1'b0;
    for (int i = 13; i < 15; i++) begin
      issue_valid = 1'b1;
      issue_inst = mk(i);
      cyc();
    end
    issue_inst = mk(3);
    resp_valid = 1'b1;
    resp_rd = 5'd13;
    cyc();
    resp_valid = 1'b0;
    check("s6_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1 check("s6_cmd_valid", cmd_valid, 0);
    check("s6_cmd_inst", cmd_inst, 0);
    check("s6_pending", rd_pending, 0);
    check("s6_wb_valid", wb_valid, 0);
    check("s6_wb_data", wb_data, 0);
    check("s6_busy", busy, 0);
    check("s6_ready", issue_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("s6_ready_after", issue_ready, 1);
    cyc();
    issue_valid = 1'b0;
    #1 check("s6_pending_after", rd_pending, 32'h8);
    check("s6_cmd_after", cmd_valid, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
